// File: rtl/obstacle_spawner.sv
// -----------------------------------------------------------------------------
// obstacle_spawner
//
// Spawn scheduler for the Dino-run obstacle stream. It asks the random
// generator for exactly one advance per obstacle. The current random word
// picks the obstacle type and the frame gap that comes before the obstacle.
// When the gap has elapsed, the block offers the obstacle to the renderer
// over a valid/ready handshake.
//
// Ports:
//   clk_i          system clock; all logic on the rising edge
//   rst_i          synchronous reset, active-high
//   run_i          game running; low = paused or game over
//   tick_i         one-cycle frame tick pulse
//   rand_i[15:0]   current random word from the generator
//   lfsr_next_o    one-cycle request to advance the generator (DRAW only)
//   spawn_valid_o  spawn request valid (SPAWN only)
//   spawn_ready_i  renderer accepts the spawn
//   spawn_type_o   0 small cactus, 1 large cactus, 2 cactus group, 3 bird
//   spawn_count_o  obstacles accepted since reset; saturates at 255
//
// Parameters:
//   MIN_GAP   minimum frame ticks between draw and spawn (>= 1)
//   GAP_BITS  number of random LSBs added to MIN_GAP
//             (MIN_GAP + 2**GAP_BITS - 1 must fit in 8 bits)
// -----------------------------------------------------------------------------
module obstacle_spawner #(
  parameter int MIN_GAP  = 16,
  parameter int GAP_BITS = 6
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        run_i,
  input  logic        tick_i,
  input  logic [15:0] rand_i,
  output logic        lfsr_next_o,
  output logic        spawn_valid_o,
  input  logic        spawn_ready_i,
  output logic [1:0]  spawn_type_o,
  output logic [7:0]  spawn_count_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAW  = 2'd1,
    ST_GAP   = 2'd2,
    ST_SPAWN = 2'd3
  } state_t;

  state_t      r_state;
  logic [7:0]  r_gap;         // frame ticks still to wait in GAP
  logic [1:0]  r_type;        // type drawn for the pending obstacle
  logic [1:0]  r_spawn_type;  // type presented to the renderer
  logic [7:0]  r_count;

  logic [7:0]  w_gap_init;
  logic        w_unused_rand;

  // Gap length drawn from the random LSBs, zero-extended onto MIN_GAP.
  assign w_gap_init = 8'(MIN_GAP) + 8'(rand_i[GAP_BITS-1:0]);

  // Bits between the gap field and the type field carry no meaning here.
  assign w_unused_rand = ^rand_i[13:GAP_BITS];

  // Both handshake-side strobes are pure decodes of the state register,
  // so no input reaches an output through combinational logic.
  assign lfsr_next_o   = (r_state == ST_DRAW);
  assign spawn_valid_o = (r_state == ST_SPAWN);
  assign spawn_type_o  = r_spawn_type;
  assign spawn_count_o = r_count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_gap        <= 8'd0;
      r_type       <= 2'd0;
      r_spawn_type <= 2'd0;
      r_count      <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (run_i) begin
            r_state <= ST_DRAW;
          end
        end

        // Single cycle: the generator advance is requested while the
        // present word is captured, so the word used is the pre-advance one.
        // A tick arriving here is deliberately not counted.
        ST_DRAW: begin
          r_gap   <= w_gap_init;
          r_type  <= rand_i[15:14];
          r_state <= run_i ? ST_GAP : ST_IDLE;
        end

        // Pause wins over a coincident tick; the remaining gap is abandoned
        // and a fresh one is drawn on resume.
        ST_GAP: begin
          if (!run_i) begin
            r_state <= ST_IDLE;
          end else if (tick_i) begin
            r_gap <= r_gap - 8'd1;
            if (r_gap == 8'd1) begin
              r_state      <= ST_SPAWN;
              r_spawn_type <= r_type;
            end
          end
        end

        // Valid is held until accepted, regardless of run_i or tick_i.
        ST_SPAWN: begin
          if (spawn_ready_i) begin
            if (r_count != 8'hFF) begin
              r_count <= r_count + 8'd1;
            end
            r_state <= run_i ? ST_DRAW : ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obstacle_spawner.sv
// -----------------------------------------------------------------------------
// tb_obstacle_spawner
//
// Self-checking bench for obstacle_spawner. The main instance uses the default
// parameters. A second instance, with MIN_GAP=1 and GAP_BITS=1, exercises
// count saturation. The expected behaviour is modelled per obstacle: gap
// length = MIN_GAP + low random bits, type = top two bits, and an accepted
// count that saturates at 255.
// -----------------------------------------------------------------------------
module tb_obstacle_spawner;

  localparam int MIN_GAP  = 16;
  localparam int GAP_BITS = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic        rst, run, tick, ready;
  logic [15:0] rnd;
  logic        lfsr, valid;
  logic [1:0]  stype;
  logic [7:0]  scount;

  // saturation instance
  logic        rst_s, run_s, tick_s, ready_s;
  logic [15:0] rnd_s;
  logic        lfsr_s, valid_s;
  logic [1:0]  stype_s;
  logic [7:0]  scount_s;

  int n_checks = 0;
  int n_fail   = 0;
  int m_count  = 0;   // model: accepted obstacles, saturating

  obstacle_spawner #(.MIN_GAP(MIN_GAP), .GAP_BITS(GAP_BITS)) dut (
    .clk_i(clk), .rst_i(rst), .run_i(run), .tick_i(tick), .rand_i(rnd),
    .lfsr_next_o(lfsr), .spawn_valid_o(valid), .spawn_ready_i(ready),
    .spawn_type_o(stype), .spawn_count_o(scount)
  );

  obstacle_spawner #(.MIN_GAP(1), .GAP_BITS(1)) dut_sat (
    .clk_i(clk), .rst_i(rst_s), .run_i(run_s), .tick_i(tick_s), .rand_i(rnd_s),
    .lfsr_next_o(lfsr_s), .spawn_valid_o(valid_s), .spawn_ready_i(ready_s),
    .spawn_type_o(stype_s), .spawn_count_o(scount_s)
  );

  function automatic int exp_gap(input logic [15:0] r);
    return MIN_GAP + (int'(r) % (1 << GAP_BITS));
  endfunction

  function automatic int sat_add(input int c);
    return (c >= 255) ? 255 : c + 1;
  endfunction

  // advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; tick = 1'b0; ready = 1'b0; rnd = 16'h0;
    cyc(); cyc();
    n_checks++;
    if ({lfsr, valid, stype, scount} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_state: got lfsr=%b valid=%b type=%0d count=%0d, expected all 0", lfsr, valid, stype, scount);
    end
    rst = 1'b0;
    repeat (3) begin
      cyc();
      n_checks++;
      if ({lfsr, valid} !== 2'b00) begin
        n_fail++;
        $display("FAIL idle_hold: got lfsr=%b valid=%b, expected 0 0", lfsr, valid);
      end
    end
  endtask

  // Plan 1: rand 0x0001 -> gap 17, type 0
  task automatic test_first_spawn();
    int n;
    run = 1'b1; rnd = 16'h0001;
    n = exp_gap(rnd);
    cyc();
    n_checks++;
    if (lfsr !== 1'b1) begin n_fail++; $display("FAIL first_draw_pulse: got %b expected 1", lfsr); end
    cyc();
    n_checks++;
    if (lfsr !== 1'b0) begin n_fail++; $display("FAIL first_draw_single: got %b expected 0", lfsr); end
    for (int k = 1; k <= n; k++) begin
      repeat ($urandom_range(0, 2)) begin
        tick = 1'b0; cyc();
        n_checks++;
        if ({valid, lfsr} !== 2'b00) begin n_fail++; $display("FAIL first_gap_idle: got valid=%b lfsr=%b expected 0 0", valid, lfsr); end
      end
      tick = 1'b1; cyc(); tick = 1'b0;
      n_checks++;
      if ({valid, lfsr} !== {(k == n), 1'b0}) begin
        n_fail++;
        $display("FAIL first_gap_tick%0d: got valid=%b lfsr=%b expected valid=%b lfsr=0", k, valid, lfsr, (k == n));
      end
    end
    n_checks++;
    if (stype !== 2'd0) begin n_fail++; $display("FAIL first_type: got %0d expected 0", stype); end
  endtask

  // Plan 3: hold off acceptance while ticks arrive; then accept
  task automatic test_backpressure();
    ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick = k[0];
      cyc();
      n_checks++;
      if ({valid, lfsr, stype, scount} !== {2'b10, 2'd0, 8'd0}) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got valid=%b lfsr=%b type=%0d count=%0d expected 1 0 0 0", k, valid, lfsr, stype, scount);
      end
    end
    tick = 1'b0; ready = 1'b1; rnd = 16'hC03F;
    cyc();
    m_count = sat_add(m_count);
    $display("spawn accepted: type=%0d count=%0d", 0, m_count);
    n_checks++;
    if ({valid, lfsr, scount} !== {2'b01, 8'(m_count)}) begin
      n_fail++;
      $display("FAIL bp_accept: got valid=%b lfsr=%b count=%0d expected 0 1 %0d", valid, lfsr, scount, m_count);
    end
    ready = 1'b0;
  endtask

  // Plan 2: 0xC03F captured in DRAW (tick there ignored) -> gap 79, type 3
  task automatic test_long_gap();
    logic [15:0] r;
    int n;
    r = 16'hC03F;
    n = exp_gap(r);
    tick = 1'b1;          // in DRAW: must not count
    cyc();
    tick = 1'b0; rnd = 16'h1234;   // generator has advanced
    n_checks++;
    if ({valid, lfsr} !== 2'b00) begin n_fail++; $display("FAIL long_after_draw: got valid=%b lfsr=%b expected 0 0", valid, lfsr); end
    for (int k = 1; k <= n; k++) begin
      tick = 1'b1; cyc(); tick = 1'b0;
      if (k >= n - 1) begin
        n_checks++;
        if (valid !== (k == n)) begin
          n_fail++;
          $display("FAIL long_gap_tick%0d: got valid=%b expected %b", k, valid, (k == n));
        end
      end
    end
    n_checks++;
    if (stype !== r[15:14]) begin n_fail++; $display("FAIL long_type: got %0d expected %0d", stype, r[15:14]); end
    ready = 1'b1; rnd = 16'($urandom);
    cyc();
    m_count = sat_add(m_count);
    $display("spawn accepted: type=%0d count=%0d", r[15:14], m_count);
    n_checks++;
    if ({lfsr, scount} !== {1'b1, 8'(m_count)}) begin
      n_fail++;
      $display("FAIL long_accept: got lfsr=%b count=%0d expected 1 %0d", lfsr, scount, m_count);
    end
    ready = 1'b0;
    cyc();   // DRAW -> GAP, captures rnd
    rnd = ~rnd;
  endtask

  // Plan 4: pause after 10 ticks, then resume with a fresh draw
  task automatic test_pause_resume();
    logic [15:0] r2;
    int n2;
    for (int k = 0; k < 10; k++) begin tick = 1'b1; cyc(); end
    tick = 1'b0; run = 1'b0;
    cyc();
    n_checks++;
    if ({valid, lfsr} !== 2'b00) begin n_fail++; $display("FAIL pause_enter: got valid=%b lfsr=%b expected 0 0", valid, lfsr); end
    for (int k = 0; k < 80; k++) begin
      tick = 1'($urandom);
      cyc();
      n_checks++;
      if ({valid, lfsr, scount} !== {2'b00, 8'(m_count)}) begin
        n_fail++;
        $display("FAIL pause_hold%0d: got valid=%b lfsr=%b count=%0d expected 0 0 %0d", k, valid, lfsr, scount, m_count);
      end
    end
    tick = 1'b0;
    r2 = 16'($urandom);
    r2[5:0] = 6'd40;
    n2 = exp_gap(r2);
    rnd = r2; run = 1'b1;
    cyc();
    n_checks++;
    if (lfsr !== 1'b1) begin n_fail++; $display("FAIL resume_draw: got %b expected 1", lfsr); end
    cyc();
    rnd = 16'h0;
    n_checks++;
    if (lfsr !== 1'b0) begin n_fail++; $display("FAIL resume_draw_single: got %b expected 0", lfsr); end
    for (int k = 1; k <= n2; k++) begin
      tick = 1'b1; cyc(); tick = 1'b0;
      if (k >= n2 - 1) begin
        n_checks++;
        if (valid !== (k == n2)) begin
          n_fail++;
          $display("FAIL resume_gap_tick%0d: got valid=%b expected %b", k, valid, (k == n2));
        end
      end
    end
    n_checks++;
    if (stype !== r2[15:14]) begin n_fail++; $display("FAIL resume_type: got %0d expected %0d", stype, r2[15:14]); end
    ready = 1'b1;
    cyc();
    m_count = sat_add(m_count);
    $display("spawn accepted: type=%0d count=%0d", r2[15:14], m_count);
    n_checks++;
    if ({lfsr, scount} !== {1'b1, 8'(m_count)}) begin
      n_fail++;
      $display("FAIL resume_accept: got lfsr=%b count=%0d expected 1 %0d", lfsr, scount, m_count);
    end
    ready = 1'b0;
  endtask

  // Random words, tick spacing and acceptance delays; starts and ends in DRAW
  task automatic test_random();
    logic [15:0] r;
    logic [1:0]  prev_type;
    int n;
    for (int it = 0; it < 6; it++) begin
      prev_type = stype;
      r = 16'($urandom);
      n = exp_gap(r);
      rnd = r; tick = 1'($urandom);
      cyc();
      tick = 1'b0; rnd = 16'($urandom);
      for (int k = 1; k <= n; k++) begin
        repeat ($urandom_range(0, 2)) begin
          tick = 1'b0; cyc();
          n_checks++;
          if ({valid, lfsr, stype} !== {2'b00, prev_type}) begin
            n_fail++;
            $display("FAIL rand%0d_idle: got valid=%b lfsr=%b type=%0d expected 0 0 %0d", it, valid, lfsr, stype, prev_type);
          end
        end
        tick = 1'b1; cyc(); tick = 1'b0;
        n_checks++;
        if ({valid, lfsr} !== {(k == n), 1'b0}) begin
          n_fail++;
          $display("FAIL rand%0d_tick%0d: got valid=%b lfsr=%b expected valid=%b lfsr=0", it, k, valid, lfsr, (k == n));
        end
      end
      repeat ($urandom_range(0, 3)) begin
        tick = 1'($urandom);
        cyc();
        n_checks++;
        if ({valid, lfsr, stype, scount} !== {2'b10, r[15:14], 8'(m_count)}) begin
          n_fail++;
          $display("FAIL rand%0d_wait: got valid=%b lfsr=%b type=%0d count=%0d expected 1 0 %0d %0d", it, valid, lfsr, stype, scount, r[15:14], m_count);
        end
      end
      n_checks++;
      if (stype !== r[15:14]) begin n_fail++; $display("FAIL rand%0d_type: got %0d expected %0d", it, stype, r[15:14]); end
      tick = 1'b0; ready = 1'b1;
      cyc();
      ready = 1'b0;
      m_count = sat_add(m_count);
      $display("spawn accepted: type=%0d gap=%0d count=%0d", r[15:14], n, m_count);
      n_checks++;
      if ({valid, lfsr, scount} !== {2'b01, 8'(m_count)}) begin
        n_fail++;
        $display("FAIL rand%0d_accept: got valid=%b lfsr=%b count=%0d expected 0 1 %0d", it, valid, lfsr, scount, m_count);
      end
    end
  endtask

  // Plan 5: reset during a pending spawn
  task automatic test_reset_mid_handshake();
    logic [15:0] r;
    r = 16'($urandom);
    rnd = r;
    cyc();
    repeat (exp_gap(r)) begin tick = 1'b1; cyc(); end
    tick = 1'b0; ready = 1'b0;
    n_checks++;
    if (valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got valid=%b expected 1", valid); end
    rst = 1'b1;
    cyc();
    m_count = 0;
    n_checks++;
    if ({valid, lfsr, stype, scount} !== 12'h000) begin
      n_fail++;
      $display("FAIL rstmid_state: got valid=%b lfsr=%b type=%0d count=%0d expected all 0", valid, lfsr, stype, scount);
    end
    cyc();   // run still high while reset held
    n_checks++;
    if ({valid, lfsr} !== 2'b00) begin n_fail++; $display("FAIL rstmid_held: got valid=%b lfsr=%b expected 0 0", valid, lfsr); end
    rst = 1'b0; run = 1'b0;
    repeat (3) begin
      tick = 1'b1; cyc();
      n_checks++;
      if ({valid, lfsr, scount} !== 10'h000) begin
        n_fail++;
        $display("FAIL rstmid_idle: got valid=%b lfsr=%b count=%0d expected 0 0 0", valid, lfsr, scount);
      end
    end
    tick = 1'b0; run = 1'b1;
    cyc();
    n_checks++;
    if (lfsr !== 1'b1) begin n_fail++; $display("FAIL rstmid_restart: got lfsr=%b expected 1", lfsr); end
    run = 1'b0;
    cyc();
    n_checks++;
    if ({valid, lfsr} !== 2'b00) begin n_fail++; $display("FAIL rstmid_draw_to_idle: got valid=%b lfsr=%b expected 0 0", valid, lfsr); end
  endtask

  // Plan 6: minimum spacing, 260 spawns, count saturates at 255
  task automatic test_saturation();
    int spawns, pulses, cycles;
    spawns = 0; pulses = 0; cycles = 0;
    rst_s = 1'b1; run_s = 1'b0; tick_s = 1'b1; ready_s = 1'b1; rnd_s = 16'h0;
    cyc();
    rst_s = 1'b0; run_s = 1'b1;
    while (spawns < 260 && cycles < 2000) begin
      cyc();
      cycles++;
      n_checks++;
      if (scount_s !== 8'((spawns > 255) ? 255 : spawns)) begin
        n_fail++;
        $display("FAIL sat_count_cyc%0d: got %0d expected %0d", cycles, scount_s, (spawns > 255) ? 255 : spawns);
      end
      if (lfsr_s) pulses++;
      if (valid_s) spawns++;
    end
    n_checks++;
    if (spawns != 260) begin n_fail++; $display("FAIL sat_timeout: got %0d spawns expected 260", spawns); end
    n_checks++;
    if (pulses != 260) begin n_fail++; $display("FAIL sat_pulses: got %0d expected 260", pulses); end
    cyc();
    n_checks++;
    if (scount_s !== 8'd255) begin n_fail++; $display("FAIL sat_final: got %0d expected 255", scount_s); end
    $display("saturation run: spawns=%0d draws=%0d count=%0d", spawns, pulses, scount_s);
  endtask

  initial begin
    rst_s = 1'b1; run_s = 1'b0; tick_s = 1'b0; ready_s = 1'b0; rnd_s = 16'h0;
    test_reset();
    test_first_spawn();
    test_backpressure();
    test_long_gap();
    test_pause_resume();
    test_random();
    test_reset_mid_handshake();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
